mux_arb: RTL and testbench
==========================

# mux_arb

Registered N-input arbitrating multiplexer with valid/ready handshake; parametrised successor of the datapath select muxes. It merges `NUM_IN` request streams, for example instruction-fetch and data-memory requests competing for one bus port, onto a single output. Selection is made by an internal arbiter instead of an external select. The arbiter runs in fixed-priority or round-robin mode, and the output is held in a one-stage pipeline register.

## Interface
- `WIDTH`, 32, data width per channel
- `NUM_IN`, 4, number of input channels (2..16)
- `SEL_W`, `$clog2(NUM_IN)`, width of channel index (localparam, not overridable)
- `clk`  input  1  clock, rising edge
- `rst`  input  1  asynchronous, active-low reset (one clock, async active-low reset; fixed)
- `mode`  input  1  0 = fixed priority (index 0 highest), 1 = round-robin
- `in_valid`  input  NUM_IN  per-channel request valid
- `in_data`  input  NUM_IN*WIDTH  flattened; channel i at bits [i*WIDTH +: WIDTH]
- `in_ready`  output  NUM_IN  per-channel accept; at most one bit set
- `out_valid`  output  1  output register holds a beat
- `out_data`  output  WIDTH  registered data
- `out_sel`  output  SEL_W  index of channel that supplied `out_data`
- `out_ready`  input  1  downstream accept

## Operation
- Transfer on a channel: `in_valid[i] & in_ready[i]`. Transfer on the output: `out_valid & out_ready`.
- `load = ~out_valid | out_ready`. The register accepts a new beat when it is empty or draining in the same cycle.
- Grant is one-hot over requesting channels:
  - Fixed mode: lowest-index valid channel.
  - Round-robin mode: first valid channel searching upward from `ptr`, with wrap from NUM_IN-1 to 0.
- `in_ready[i] = grant[i] & load`. This is combinational from `in_valid`, `mode`, `ptr`, `out_valid` and `out_ready`.
- On any input transfer from channel g:
  - `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`.
  - Round-robin mode: `ptr <= (g+1) mod NUM_IN`. Wrap is explicit; NUM_IN need not be a power of two.
  - Fixed mode: `ptr` is unchanged.
- Output transfer with no input transfer: `out_valid <= 0`. `out_data` and `out_sel` hold their last values.
- No valid inputs: all `in_ready` are 0, with no state change except the output drain.
- Stall (`out_valid & ~out_ready`): all `in_ready` are 0. `out_data` and `out_sel` are stable until accepted. The grant may move, because nothing has been accepted.
- A `mode` change takes effect on the next arbitration cycle. `ptr` is retained, so a switch back to round-robin resumes from the stored pointer.

## Timing
- Reset (async assert, sync-safe deassert by system): `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`. `in_ready` is then 0 because no channel is valid or granted before inputs arrive.
- Latency: input transfer in cycle n gives `out_valid` in cycle n+1.
- Throughput: one beat per cycle while `out_ready=1`. Back-to-back beats have no bubble.
- Simultaneous output drain and input load in one cycle: the new beat replaces the old, and `out_valid` stays 1.
- Reset asserted mid-stream: the output beat is discarded immediately, with no transfer completed in that cycle. `ptr` returns to 0.
- Fairness in round-robin mode: with all channels continuously valid and `out_ready=1`, each channel is served exactly once every NUM_IN cycles.

## Structure
- `MUX_ARB_FIXED=1'b0` and `MUX_ARB_RR=1'b1` go in the shared defines header with the other datapath select encodings.
- Sub-module `rr_pick`:
  - Parameter `N`; inputs `req[N]` and `start[SEL_W]`.
  - Outputs one-hot `gnt[N]`, encoded `idx[SEL_W]` and `any`.
  - Fixed mode instantiates the same block with `start=0`.
- The top level holds the output register, `ptr` register and load/ready logic.

## Test plan
- Reset then single request: `in_valid=4'b0100`, `in_data[2]=32'hDEAD_BEEF`, `out_ready=1` -> `in_ready=4'b0100` in that cycle; next cycle `out_valid=1`, `out_data=32'hDEADBEEF`, `out_sel=2`.
- Fixed priority: `mode=0`, `in_valid=4'b1111` held 4 cycles -> channel 0 granted every cycle; `out_sel` = 0,0,0,0.
- Round-robin fairness: `mode=1`, `in_valid=4'b1111`, `out_ready=1` -> `out_sel` = 0,1,2,3,0,1,2,3 on successive cycles. Sparse `in_valid=4'b1010` -> 1,3,1,3.
- Backpressure: `out_ready=0` for 3 cycles with `out_valid=1` -> `in_ready=0`, `out_data`/`out_sel` unchanged; `out_ready=1` -> drain and a new load in the same cycle, `out_valid` stays 1.
- Non-power-of-two: `NUM_IN=3`, `mode=1`, all valid -> `out_sel` = 0,1,2,0 with no index 3 and no skipped channel.
- Async reset mid-stream: `rst` low between clock edges while `out_valid=1` -> `out_valid=0` immediately. After release with all valid in RR mode, the first grant is channel 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// mux_arb shared definitions: arbitration mode encodings and index wrap helper.
package mux_arb_pkg;

    localparam logic MUX_ARB_FIXED = 1'b0;
    localparam logic MUX_ARB_RR    = 1'b1;

    // Modular add for a < n and b <= n; n need not be a power of two.
    function automatic int unsigned wrap_add(
        input int unsigned a,
        input int unsigned b,
        input int unsigned n
    );
        int unsigned s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Rotating first-one picker: grants the first set req at or after start, wrapping.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] start,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int unsigned j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = wrap_add(32'(start), k, N);
            if (!any && req[j]) begin
                gnt[j] = 1'b1;
                idx    = SEL_W'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb.sv
// Registered N-input arbitrating mux with valid/ready handshake.
module mux_arb
    import mux_arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [SEL_W-1:0]  sel_q, sel_d;

    logic [SEL_W-1:0]  start;
    logic [NUM_IN-1:0] gnt;
    logic [SEL_W-1:0]  idx;
    logic              any;
    logic              load;
    logic              xfer;

    // Fixed priority is the rotating search pinned to channel 0.
    assign start = (mode == MUX_ARB_RR) ? ptr_q : '0;

    rr_pick #(.N(NUM_IN)) u_pick (
        .req   (in_valid),
        .start (start),
        .gnt   (gnt),
        .idx   (idx),
        .any   (any)
    );

    assign load     = ~valid_q | out_ready;
    assign xfer     = any & load;
    assign in_ready = gnt & {NUM_IN{load}};

    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (xfer) begin
            valid_d = 1'b1;
            data_d  = in_data[int'(idx)*WIDTH +: WIDTH];
            sel_d   = idx;
            if (mode == MUX_ARB_RR) begin
                ptr_d = SEL_W'(wrap_add(32'(idx), 1, NUM_IN));
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux_arb.sv
// Scoreboard bench for mux_arb (NUM_IN=4 main instance, NUM_IN=3 wrap instance).
module tb_mux_arb;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int N3 = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            mode;
    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [1:0]      out_sel;
    logic            out_ready;

    logic            mode3;
    logic [N3-1:0]   in_valid3;
    logic [N3*W-1:0] in_data3;
    logic [N3-1:0]   in_ready3;
    logic            out_valid3;
    logic [W-1:0]    out_data3;
    logic [1:0]      out_sel3;
    logic            out_ready3;

    mux_arb #(.WIDTH(W), .NUM_IN(N)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    mux_arb #(.WIDTH(W), .NUM_IN(N3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode3),
        .in_valid  (in_valid3),
        .in_data   (in_data3),
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_ready (out_ready3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           s;
    } beat_t;

    beat_t sb[$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    m_ptr = 0;
    bit    m_valid = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int st);
        for (int k = 0; k < N; k++) begin
            if (v[(st + k) % N]) return (st + k) % N;
        end
        return -1;
    endfunction

    task automatic rand_data();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
    endtask

    // Called just after a falling edge with inputs set; returns after next one.
    task automatic cycle();
        int g;
        bit ld;
        logic [N-1:0] er;
        beat_t b;
        #1;
        ld = !m_valid || out_ready;
        g  = pick(in_valid, mode ? m_ptr : 0);
        er = '0;
        if (g >= 0 && ld) er[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(er));
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                chk("out_data", 64'(out_data), 64'(sb[0].d));
                chk("out_sel", 64'(out_sel), 64'(sb[0].s));
                if (out_ready) void'(sb.pop_front());
            end
        end
        if (g >= 0 && ld) begin
            b.d = in_data[g*W +: W];
            b.s = g;
            sb.push_back(b);
            m_valid = 1'b1;
            if (mode) m_ptr = (g + 1) % N;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m_valid = 1'b0;
        m_ptr = 0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [2:0] e3;
        rst = 1'b0;
        mode = 1'b0;
        in_valid = '0;
        in_data = '0;
        out_ready = 1'b1;
        mode3 = 1'b1;
        in_valid3 = '0;
        in_data3 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
        out_ready3 = 1'b1;
        @(negedge clk);
        do_reset();

        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_sel", 64'(out_sel), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        @(negedge clk);

        // Non-power-of-two instance: wrap must go 2 -> 0.
        in_valid3 = 3'b111;
        for (int i = 0; i < 6; i++) begin
            e3 = 3'b001 << (i % 3);
            #1;
            chk("n3_ready", 64'(in_ready3), 64'(e3));
            @(posedge clk);
            @(negedge clk);
            chk("n3_sel", 64'(out_sel3), 64'(i % 3));
            chk("n3_data", 64'(out_data3), 64'(32'h3333_0000 + (i % 3)));
        end
        in_valid3 = '0;

        rand_data();
        in_valid = 4'b0100;
        in_data[2*W +: W] = 32'hDEAD_BEEF;
        #1;
        chk("t1_ready", 64'(in_ready), 64'(4'b0100));
        cycle();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", 64'(out_data), 64'hDEAD_BEEF);
        chk("t1_sel", 64'(out_sel), 64'd2);

        in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            cycle();
            chk("fix_sel", 64'(out_sel), 64'd0);
        end

        in_valid = '0;
        do_reset();
        mode = 1'b1;
        in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            rand_data();
            cycle();
            chk("rr_sel", 64'(out_sel), 64'(i % 4));
        end

        in_valid = '0;
        do_reset();
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            cycle();
            chk("rr_sparse", 64'(out_sel), (i % 2) ? 64'd3 : 64'd1);
        end

        mode = 1'b0;
        in_valid = 4'b0010;
        in_data[W +: W] = 32'h1111_0001;
        cycle();
        out_ready = 1'b0;
        in_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            #1;
            chk("bp_ready", 64'(in_ready), 64'd0);
            cycle();
            chk("bp_sel", 64'(out_sel), 64'd1);
            chk("bp_data", 64'(out_data), 64'h1111_0001);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_refill", 64'(out_valid), 64'd1);
        chk("bp_new_sel", 64'(out_sel), 64'd0);

        mode = 1'b1;
        in_valid = 4'b1111;
        cycle();
        cycle();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_sel", 64'(out_sel), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        m_valid = 1'b0;
        m_ptr = 0;
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        cycle();
        chk("arst_first", 64'(out_sel), 64'd0);

        for (int i = 0; i < 80; i++) begin
            in_valid = N'($urandom);
            if ($urandom_range(0, 5) == 0) mode = ~mode;
            out_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
